// File: rtl/snake_body_engine.sv
`default_nettype none
// ============================================================================
//  Module   : snake_body_engine
//  Purpose  : Parametrised snake movement/body engine. Holds up to MAX_LEN
//             body segments in a shift array, steps the head every TICK_DIV
//             enabled cycles, grows on target capture, flags wall/self
//             collision and answers registered cell queries for the colour mux.
//  Ports    : CLK, RESET (async, active-low)
//             ENABLE            - play (1) / pause (0)
//             DIRECTION[1:0]    - 00 up, 01 down, 10 left, 11 right
//             TARGET_X/Y        - target cell
//             QUERY_X/Y         - queried cell
//             QUERY_HIT[1:0]    - 00 empty, 01 body, 10 head, 11 target (reg)
//             REACHED_TARGET    - one-cycle pulse on capture, with STEP
//             BODY_HIT          - sticky collision flag
//             STEP              - one-cycle pulse per move
//             LENGTH, HEAD_X, HEAD_Y - current length and head cell
//  Revision : 1.0 - initial release
// ============================================================================
module snake_body_engine #(
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int MAX_LEN  = 32,
  parameter int LEN_W    = 6,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 5000000,
  parameter int WRAP     = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       DIRECTION,
  input  logic [X_W-1:0]   TARGET_X,
  input  logic [Y_W-1:0]   TARGET_Y,
  input  logic [X_W-1:0]   QUERY_X,
  input  logic [Y_W-1:0]   QUERY_Y,
  output logic [1:0]       QUERY_HIT,
  output logic             REACHED_TARGET,
  output logic             BODY_HIT,
  output logic             STEP,
  output logic [LEN_W-1:0] LENGTH,
  output logic [X_W-1:0]   HEAD_X,
  output logic [Y_W-1:0]   HEAD_Y
);

  localparam int         c_tick_w    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] c_dir_up    = 2'b00;
  localparam logic [1:0] c_dir_down  = 2'b01;
  localparam logic [1:0] c_dir_left  = 2'b10;
  localparam logic [1:0] c_dir_right = 2'b11;

  logic [X_W-1:0]      r_seg_x [MAX_LEN];
  logic [Y_W-1:0]      r_seg_y [MAX_LEN];
  logic [1:0]          r_dir;
  logic [c_tick_w-1:0] r_tick;
  logic [LEN_W-1:0]    r_len;
  logic                r_body_hit;
  logic                r_reached;
  logic                r_step;
  logic [1:0]          r_query_hit;

  logic                w_tick_done;
  logic                w_dir_opp;
  logic [1:0]          w_dir;
  logic [X_W-1:0]      w_nx;
  logic [Y_W-1:0]      w_ny;
  logic                w_edge;
  logic                w_grow;
  logic [LEN_W-1:0]    w_chk_len;
  logic                w_self;
  logic                w_die;
  logic                w_q_body;
  logic [1:0]          w_query_hit;

  assign w_tick_done = ENABLE && !r_body_hit && (r_tick == c_tick_w'(TICK_DIV - 1));

  // Same axis (bit 1 equal) but opposite sense (bit 0 differs) is a reversal.
  assign w_dir_opp = (DIRECTION[1] == r_dir[1]) && (DIRECTION[0] != r_dir[0]);
  assign w_dir     = w_dir_opp ? r_dir : DIRECTION;

  // Next head; w_edge marks a grid-edge crossing, whose coordinate is already
  // the wrapped one.
  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_edge = 1'b0;
    case (w_dir)
      c_dir_up: begin
        if (r_seg_y[0] == '0) begin
          w_ny   = Y_W'(GRID_H - 1);
          w_edge = 1'b1;
        end else begin
          w_ny = r_seg_y[0] - Y_W'(1);
        end
      end
      c_dir_down: begin
        if (r_seg_y[0] == Y_W'(GRID_H - 1)) begin
          w_ny   = '0;
          w_edge = 1'b1;
        end else begin
          w_ny = r_seg_y[0] + Y_W'(1);
        end
      end
      c_dir_left: begin
        if (r_seg_x[0] == '0) begin
          w_nx   = X_W'(GRID_W - 1);
          w_edge = 1'b1;
        end else begin
          w_nx = r_seg_x[0] - X_W'(1);
        end
      end
      default: begin
        if (r_seg_x[0] == X_W'(GRID_W - 1)) begin
          w_nx   = '0;
          w_edge = 1'b1;
        end else begin
          w_nx = r_seg_x[0] + X_W'(1);
        end
      end
    endcase
  end

  assign w_grow = (w_nx == TARGET_X) && (w_ny == TARGET_Y);

  // The tail vacates on a normal move, so it is only an obstacle when growing.
  assign w_chk_len = w_grow ? r_len : (r_len - LEN_W'(1));

  always_comb begin
    w_self = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < w_chk_len) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny)) begin
        w_self = 1'b1;
      end
    end
  end

  assign w_die = w_self || (w_edge && (WRAP == 0));

  // Query decode against pre-move state; priority head > body > target.
  always_comb begin
    w_q_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < r_len) && (r_seg_x[i] == QUERY_X) && (r_seg_y[i] == QUERY_Y)) begin
        w_q_body = 1'b1;
      end
    end
    if ((r_seg_x[0] == QUERY_X) && (r_seg_y[0] == QUERY_Y)) begin
      w_query_hit = 2'b10;
    end else if (w_q_body) begin
      w_query_hit = 2'b01;
    end else if ((TARGET_X == QUERY_X) && (TARGET_Y == QUERY_Y)) begin
      w_query_hit = 2'b11;
    end else begin
      w_query_hit = 2'b00;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tick      <= '0;
      r_dir       <= c_dir_right;
      r_len       <= LEN_W'(INIT_LEN);
      r_body_hit  <= 1'b0;
      r_reached   <= 1'b0;
      r_step      <= 1'b0;
      r_query_hit <= 2'b00;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          r_seg_x[i] <= X_W'(GRID_W / 2 - i);
          r_seg_y[i] <= Y_W'(GRID_H / 2);
        end else begin
          r_seg_x[i] <= '0;
          r_seg_y[i] <= '0;
        end
      end
    end else begin
      r_step      <= 1'b0;
      r_reached   <= 1'b0;
      r_query_hit <= w_query_hit;
      if (ENABLE && !r_body_hit) begin
        if (w_tick_done) begin
          r_tick <= '0;
          r_dir  <= w_dir;
          if (w_die) begin
            r_body_hit <= 1'b1;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              r_seg_x[i] <= r_seg_x[i-1];
              r_seg_y[i] <= r_seg_y[i-1];
            end
            r_seg_x[0] <= w_nx;
            r_seg_y[0] <= w_ny;
            r_step     <= 1'b1;
            if (w_grow) begin
              r_reached <= 1'b1;
              if (r_len != LEN_W'(MAX_LEN)) begin
                r_len <= r_len + LEN_W'(1);
              end
            end
          end
        end else begin
          r_tick <= r_tick + c_tick_w'(1);
        end
      end
    end
  end

  assign QUERY_HIT      = r_query_hit;
  assign REACHED_TARGET = r_reached;
  assign BODY_HIT       = r_body_hit;
  assign STEP           = r_step;
  assign LENGTH         = r_len;
  assign HEAD_X         = r_seg_x[0];
  assign HEAD_Y         = r_seg_y[0];

endmodule
`default_nettype wire
